// File: rtl/div8u4_pkg.sv
// Shared types and constants for the 8-by-4 sequential restoring divider.
package div8u4_pkg;

  localparam int DIVIDEND_W = 8;
  localparam int DIVISOR_W  = 4;

  localparam logic [DIVIDEND_W-1:0] DBZ_QUOTIENT = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div8u4_step.sv
// One combinational restoring-division step: trial-subtract the divisor
// from the 5-bit partial remainder, keep the difference if non-negative.
module div8u4_step
  import div8u4_pkg::*;
(
  input  logic [DIVISOR_W:0]   part_rem,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] rem_out,
  output logic                 q_bit
);

  logic [DIVISOR_W+1:0] diff;
  logic                 unused_diff_bit;

  // The kept difference is always below the divisor, so bit DIVISOR_W is zero.
  always_comb begin
    diff    = {1'b0, part_rem} - {2'b00, divisor};
    q_bit   = ~diff[DIVISOR_W+1];
    rem_out = q_bit ? diff[DIVISOR_W-1:0] : part_rem[DIVISOR_W-1:0];
  end

  assign unused_diff_bit = diff[DIVISOR_W];

endmodule

// File: rtl/div8u4_seq.sv
// Sequential 8-bit by 4-bit unsigned restoring divider, STEPS_PER_CYCLE steps per clock.
// Optional result self-check enabled by defining DIV8U4_RESIDUE_CHECK_EN.
module div8u4_seq
  import div8u4_pkg::*;
#(
  parameter int STEPS_PER_CYCLE = 1
)
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  check_err
);

  if (STEPS_PER_CYCLE != 1 && STEPS_PER_CYCLE != 2 &&
      STEPS_PER_CYCLE != 4 && STEPS_PER_CYCLE != 8) begin : g_bad_steps
    $error("div8u4_seq: STEPS_PER_CYCLE must be 1, 2, 4 or 8");
  end

  localparam int              CYCLES   = DIVIDEND_W / STEPS_PER_CYCLE;
  localparam logic [3:0]      CNT_LAST = 4'(CYCLES - 1);

  state_t                  state_q, state_d;
  logic [DIVIDEND_W-1:0]   work_q, work_d;
  logic [DIVISOR_W-1:0]    rem_q, rem_d;
  logic [DIVISOR_W-1:0]    dvs_q, dvs_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [DIVIDEND_W-1:0]   quotient_q, quotient_d;
  logic [DIVISOR_W-1:0]    remainder_q, remainder_d;
  logic                    dbz_q, dbz_d;

  logic [STEPS_PER_CYCLE-1:0] q_bits;
  logic [DIVIDEND_W-1:0]      work_next;
  logic [DIVISOR_W-1:0]       rem_last;

  // work_q shifts dividend bits out of the top while quotient bits enter at the bottom.
  for (genvar k = 0; k < STEPS_PER_CYCLE; k++) begin : g_step
    logic [DIVISOR_W-1:0] rem_in;
    logic [DIVISOR_W-1:0] rem_nxt;
    logic                 qb;

    if (k == 0) begin : g_first
      assign rem_in = rem_q;
    end else begin : g_next
      assign rem_in = g_step[k-1].rem_nxt;
    end

    div8u4_step u_step (
      .part_rem ({rem_in, work_q[DIVIDEND_W-1-k]}),
      .divisor  (dvs_q),
      .rem_out  (rem_nxt),
      .q_bit    (qb)
    );

    assign q_bits[STEPS_PER_CYCLE-1-k] = qb;
  end

  assign rem_last  = g_step[STEPS_PER_CYCLE-1].rem_nxt;
  assign work_next = (work_q << STEPS_PER_CYCLE) | DIVIDEND_W'(q_bits);

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, DONE: if (start) state_d = (divisor != '0) ? RUN : DONE;
      RUN:        if (cnt_q == '0) state_d = DONE;
      default:    state_d = IDLE;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      RUN:     busy = 1'b1;
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

`ifdef DIV8U4_RESIDUE_CHECK_EN
  logic [DIVIDEND_W-1:0] dvd_cap_q, dvd_cap_d;
  logic                  check_err_q, check_err_d;
  logic [11:0]           recon;
  logic                  res_bad;

  assign recon   = 12'(work_next) * 12'(dvs_q) + 12'(rem_last);
  assign res_bad = (recon != 12'(dvd_cap_q)) || (rem_last >= dvs_q);
`endif

  always_comb begin
    work_d      = work_q;
    rem_d       = rem_q;
    dvs_d       = dvs_q;
    cnt_d       = cnt_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
`ifdef DIV8U4_RESIDUE_CHECK_EN
    dvd_cap_d   = dvd_cap_q;
    check_err_d = check_err_q;
`endif
    case (state_q)
      IDLE, DONE: begin
        if (start && divisor != '0) begin
          work_d    = dividend;
          rem_d     = '0;
          dvs_d     = divisor;
          cnt_d     = CNT_LAST;
`ifdef DIV8U4_RESIDUE_CHECK_EN
          dvd_cap_d = dividend;
`endif
        end else if (start) begin
          quotient_d  = DBZ_QUOTIENT;
          remainder_d = dividend[DIVISOR_W-1:0];
          dbz_d       = 1'b1;
`ifdef DIV8U4_RESIDUE_CHECK_EN
          check_err_d = 1'b0;
`endif
        end
      end
      RUN: begin
        work_d = work_next;
        rem_d  = rem_last;
        cnt_d  = cnt_q - 4'd1;
        if (cnt_q == '0) begin
          quotient_d  = work_next;
          remainder_d = rem_last;
          dbz_d       = 1'b0;
`ifdef DIV8U4_RESIDUE_CHECK_EN
          check_err_d = res_bad;
`endif
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q      <= '0;
      rem_q       <= '0;
      dvs_q       <= '0;
      cnt_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
`ifdef DIV8U4_RESIDUE_CHECK_EN
      dvd_cap_q   <= '0;
      check_err_q <= 1'b0;
`endif
    end else begin
      work_q      <= work_d;
      rem_q       <= rem_d;
      dvs_q       <= dvs_d;
      cnt_q       <= cnt_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
`ifdef DIV8U4_RESIDUE_CHECK_EN
      dvd_cap_q   <= dvd_cap_d;
      check_err_q <= check_err_d;
`endif
    end
  end

  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
`ifdef DIV8U4_RESIDUE_CHECK_EN
  assign check_err   = check_err_q;
`else
  assign check_err   = 1'b0;
`endif

endmodule

// File: doc/div8u4_seq.md
DIV8U4_SEQ -- requirements
Module: div8u4_seq

Interface
REQ-001 SHALL provide parameter STEPS_PER_CYCLE, default 1, the restoring-division steps per clock; legal values 1, 2, 4, 8; any other value is an elaboration error.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset; synchronous, active-low.
REQ-004 SHALL have port start, input, 1, request to begin a division; sampled on rising edge.
REQ-005 SHALL have port dividend, input, 8, unsigned dividend; captured when start is accepted.
REQ-006 SHALL have port divisor, input, 4, unsigned divisor; captured when start is accepted.
REQ-007 SHALL have port busy, output, 1, high while state is RUN.
REQ-008 SHALL have port done, output, 1, high while state is DONE (result valid).
REQ-009 SHALL have port quotient, output, 8, unsigned quotient.
REQ-010 SHALL have port remainder, output, 4, unsigned remainder.
REQ-011 SHALL have port div_by_zero, output, 1, result flag: captured divisor was 0.
REQ-012 SHALL have port check_err, output, 1, result self-check failure flag (REQ-030).

Function
REQ-013 SHALL implement FSM states IDLE, RUN, DONE.
REQ-014 IDLE or DONE with start=1 and divisor!=0 SHALL capture operands, clear done, and go to RUN.
REQ-015 IDLE or DONE with start=1 and divisor==0 SHALL go to DONE on that edge with quotient=8'hFF, remainder=dividend[3:0], div_by_zero=1, check_err=0.
REQ-016 RUN SHALL perform STEPS_PER_CYCLE restoring steps per cycle, MSB of dividend first; after 8/STEPS_PER_CYCLE RUN cycles it SHALL go to DONE.
REQ-017 Nonzero-divisor latency: done SHALL rise exactly 8/STEPS_PER_CYCLE+1 edges after the edge accepting start.
REQ-018 Restoring step: partial remainder 5 bits wide {rem[3:0], next dividend bit}; subtract zero-extended divisor; if non-negative, keep the difference and shift in quotient bit 1; else restore and shift in 0.
REQ-019 Results SHALL satisfy quotient*divisor+remainder==dividend and remainder<divisor for every divisor!=0.
REQ-020 start while in RUN SHALL be ignored; operands and progress are unaffected.
REQ-021 DONE SHALL hold quotient, remainder, div_by_zero, check_err stable until the next accepted start or reset.
REQ-022 DONE with start=1 SHALL accept back-to-back: done drops on the next edge; the new operation proceeds per REQ-014/015.
REQ-023 busy and done SHALL never be high together; in IDLE both are 0.
REQ-024 quotient and remainder SHALL show the previous result (or reset values) during RUN; internal working registers are not exposed.

Reset
REQ-025 rst_n=0 at a rising edge SHALL force IDLE and busy=0, done=0, quotient=0, remainder=0, div_by_zero=0, check_err=0.
REQ-026 Reset in RUN or DONE SHALL abort without producing done; reset has priority over start.
REQ-027 start SHALL be ignored on any edge where rst_n=0.

Configuration
REQ-028 Macro DIV8U4_RESIDUE_CHECK_EN SHALL control the self-check.
REQ-029 Without the macro, check_err SHALL be tied 0 and no check logic SHALL be synthesized.
REQ-030 With the macro, on the RUN->DONE edge check_err SHALL be set if 12-bit quotient*divisor+remainder != zero-extended dividend or remainder >= divisor; it is held per REQ-021.

Structure
REQ-031 Package div8u4_pkg SHALL hold the state enum (IDLE/RUN/DONE), DIVIDEND_W=8, DIVISOR_W=4, and the division-by-zero quotient constant 8'hFF.
REQ-032 Sub-module div8u4_step SHALL be a purely combinational single restoring step (5-bit partial remainder in, divisor in; next remainder and quotient bit out), instantiated STEPS_PER_CYCLE times in a chain.

Verification
REQ-033 dividend=200, divisor=7, STEPS_PER_CYCLE=1 -> done on the 9th edge after start; quotient=28, remainder=4, div_by_zero=0.
REQ-034 255/1 and 5/15 at STEPS_PER_CYCLE=4 -> {255,0} after 3 edges, then back-to-back {0,5} after 3 more edges.
REQ-035 dividend=13, divisor=0 -> done after 1 edge; quotient=8'hFF, remainder=4'hD, div_by_zero=1.
REQ-036 start with 100/3, then start with 9/9 pulsed mid-RUN -> ignored; result quotient=33, remainder=1.
REQ-037 rst_n low in 4th RUN cycle -> next edge IDLE, all outputs 0; no done pulse.
REQ-038 Macro defined, force one quotient register bit flipped during RUN (100/3) -> done with check_err=1; without the macro check_err=0.
